// File: rtl/cache_types.sv
// Shared types for the L1 line arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   arb_op_t    : operation latched at grant (OP_READ, OP_WRITE)
//   STARVE_CNT_W: width of the starvation counter (supports limits 1..15)
// rv32i_word is deliberately not redefined here; it stays in rv32i_types.
package cache_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int unsigned STARVE_CNT_W = 4;

  // A requester asserting read and write together is treated as a write,
  // so a dirty eviction always goes out before the refill.
  function automatic arb_op_t pick_op(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the line arbiter.
// Counts D-cache grants that were made while the I-cache was waiting, and
// reports when the configured limit has been reached.
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset, clears the count
//   inc       in   count one more starved cycle (saturates at LIMIT)
//   clr       in   clear the count (takes priority over inc)
//   at_limit  out  count equals LIMIT
//   o_cnt     out  current count, for observation
module starve_counter
  import cache_types::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic                    at_limit,
  output logic [STARVE_CNT_W-1:0] o_cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = LIMIT[STARVE_CNT_W-1:0];

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == LIMIT_V);
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/line_arbiter.sv
// Shares the single cacheline port of the cacheline adaptor between the L1
// I-cache and D-cache when no L2 is present. D-cache has priority; after
// STARVE_LIMIT consecutive D grants with the I-cache waiting, the I-cache is
// granted. Address, write data and operation are latched at grant so the
// adaptor sees stable inputs for the whole burst.
//
// Handshake: a requester raises read or write and holds it, unchanged, until
// its pmem_resp pulses for one cycle; that pulse is the only qualifier of
// pmem_rdata. Toward the adaptor, c_pmem_read/write stay high from the cycle
// after grant until the cycle c_pmem_resp is seen, then drop for at least one
// IDLE turnaround cycle.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_pmem_* / d_pmem_*       I-cache / D-cache line ports
//   c_pmem_*                  adaptor-side line port
//   o_dbg_state               current FSM state (arb_state_t encoding)
//   o_dbg_starve_cnt          current starvation count
//   perf_i_grants, perf_d_grants, perf_conflict
//                             performance counters, present only when
//                             ARB_PERF_CNT_EN is defined
//
// Configuration macro: ARB_PERF_CNT_EN (undefined by default).
module line_arbiter
  import cache_types::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic [ADDR_W-1:0]       i_pmem_address,
  output logic [LINE_W-1:0]       i_pmem_rdata,
  input  logic [LINE_W-1:0]       i_pmem_wdata,
  input  logic                    i_pmem_read,
  input  logic                    i_pmem_write,
  output logic                    i_pmem_resp,

  input  logic [ADDR_W-1:0]       d_pmem_address,
  output logic [LINE_W-1:0]       d_pmem_rdata,
  input  logic [LINE_W-1:0]       d_pmem_wdata,
  input  logic                    d_pmem_read,
  input  logic                    d_pmem_write,
  output logic                    d_pmem_resp,

  output logic [ADDR_W-1:0]       c_pmem_address,
  input  logic [LINE_W-1:0]       c_pmem_rdata,
  output logic [LINE_W-1:0]       c_pmem_wdata,
  output logic                    c_pmem_read,
  output logic                    c_pmem_write,
  input  logic                    c_pmem_resp,

  output logic [1:0]              o_dbg_state,
  output logic [STARVE_CNT_W-1:0] o_dbg_starve_cnt
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]             perf_i_grants,
  output logic [31:0]             perf_d_grants,
  output logic [31:0]             perf_conflict
`endif
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_c_read;
  logic              r_c_write;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_idle;
  logic              w_at_limit;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_starve_inc;
  logic              w_starve_clr;
  arb_op_t           w_win_op;
  logic [ADDR_W-1:0] w_win_addr;
  logic [LINE_W-1:0] w_win_wdata;

  assign w_i_req = i_pmem_read | i_pmem_write;
  assign w_d_req = d_pmem_read | d_pmem_write;
  assign w_idle  = (r_state == IDLE);

  // D wins unless the I-cache has been passed over STARVE_LIMIT times.
  assign w_grant_i = w_idle && w_i_req && (!w_d_req || w_at_limit);
  assign w_grant_d = w_idle && w_d_req && !w_grant_i;

  // Only D grants that leave the I-cache waiting count toward starvation.
  assign w_starve_inc = w_grant_d && w_i_req;
  assign w_starve_clr = w_grant_i || (w_grant_d && !w_i_req);

  assign w_win_op    = w_grant_i ? pick_op(i_pmem_write) : pick_op(d_pmem_write);
  assign w_win_addr  = w_grant_i ? i_pmem_address : d_pmem_address;
  assign w_win_wdata = w_grant_i ? i_pmem_wdata   : d_pmem_wdata;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (w_starve_inc),
    .clr      (w_starve_clr),
    .at_limit (w_at_limit),
    .o_cnt    (o_dbg_starve_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_read  <= 1'b0;
      r_c_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i || w_grant_d) begin
            r_state   <= w_grant_i ? BUSY_I : BUSY_D;
            r_addr    <= w_win_addr;
            r_wdata   <= w_win_wdata;
            r_c_read  <= (w_win_op == OP_READ);
            r_c_write <= (w_win_op == OP_WRITE);
          end
        end
        BUSY_I, BUSY_D: begin
          // Latches are kept after completion; only the op strobes drop,
          // which gives the adaptor its mandatory turnaround cycle.
          if (c_pmem_resp) begin
            r_state   <= IDLE;
            r_c_read  <= 1'b0;
            r_c_write <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_c_read  <= 1'b0;
          r_c_write <= 1'b0;
        end
      endcase
    end
  end

  assign c_pmem_address = r_addr;
  assign c_pmem_wdata   = r_wdata;
  assign c_pmem_read    = r_c_read;
  assign c_pmem_write   = r_c_write;

  // Completion is forwarded in the same cycle; a resp seen in IDLE is dropped.
  assign i_pmem_resp = (r_state == BUSY_I) && c_pmem_resp;
  assign d_pmem_resp = (r_state == BUSY_D) && c_pmem_resp;

  // Both caches see the adaptor data unconditionally; resp qualifies it.
  assign i_pmem_rdata = c_pmem_rdata;
  assign d_pmem_rdata = c_pmem_rdata;

  assign o_dbg_state = r_state;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_conf;

  // All three counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_i    <= '0;
      r_perf_d    <= '0;
      r_perf_conf <= '0;
    end else begin
      if (w_grant_i) r_perf_i <= r_perf_i + 32'd1;
      if (w_grant_d) r_perf_d <= r_perf_d + 32'd1;
      if (w_idle && w_i_req && w_d_req) r_perf_conf <= r_perf_conf + 32'd1;
    end
  end

  assign perf_i_grants = r_perf_i;
  assign perf_d_grants = r_perf_d;
  assign perf_conflict = r_perf_conf;
`else
  // Performance counters are not built in this configuration.
`endif

  // A requester must not raise read and write together.
  a_i_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_pmem_read && i_pmem_write));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(d_pmem_read && d_pmem_write));

  // A granted requester must hold its request until its resp pulse.
  a_i_hold: assert property (@(posedge clk) disable iff (!reset_n)
    ((r_state == BUSY_I) && !c_pmem_resp) |-> w_i_req);
  a_d_hold: assert property (@(posedge clk) disable iff (!reset_n)
    ((r_state == BUSY_D) && !c_pmem_resp) |-> w_d_req);

endmodule

// File: tb/tb_line_arbiter.sv
module tb_line_arbiter;
  import cache_types::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LIMIT  = 4;
  localparam int SB_W   = 35;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  initial begin
    forever #5 clk = ~clk;
  end

  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic [LINE_W-1:0] i_pmem_wdata = '0;
  logic              i_pmem_read = 1'b0;
  logic              i_pmem_write = 1'b0;
  logic              i_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic              d_pmem_resp;
  logic [ADDR_W-1:0] c_pmem_address;
  logic [LINE_W-1:0] c_pmem_rdata = '0;
  logic [LINE_W-1:0] c_pmem_wdata;
  logic              c_pmem_read;
  logic              c_pmem_write;
  logic              c_pmem_resp = 1'b0;
  logic [1:0]        o_dbg_state;
  logic [3:0]        o_dbg_starve_cnt;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       perf_i_grants;
  logic [31:0]       perf_d_grants;
  logic [31:0]       perf_conflict;
`endif

  line_arbiter #(
    .ADDR_W       (ADDR_W),
    .LINE_W       (LINE_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_pmem_address   (i_pmem_address),
    .i_pmem_rdata     (i_pmem_rdata),
    .i_pmem_wdata     (i_pmem_wdata),
    .i_pmem_read      (i_pmem_read),
    .i_pmem_write     (i_pmem_write),
    .i_pmem_resp      (i_pmem_resp),
    .d_pmem_address   (d_pmem_address),
    .d_pmem_rdata     (d_pmem_rdata),
    .d_pmem_wdata     (d_pmem_wdata),
    .d_pmem_read      (d_pmem_read),
    .d_pmem_write     (d_pmem_write),
    .d_pmem_resp      (d_pmem_resp),
    .c_pmem_address   (c_pmem_address),
    .c_pmem_rdata     (c_pmem_rdata),
    .c_pmem_wdata     (c_pmem_wdata),
    .c_pmem_read      (c_pmem_read),
    .c_pmem_write     (c_pmem_write),
    .c_pmem_resp      (c_pmem_resp),
    .o_dbg_state      (o_dbg_state),
    .o_dbg_starve_cnt (o_dbg_starve_cnt)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_grants    (perf_i_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_conflict    (perf_conflict)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [SB_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int i_done   = 0;
  int d_done   = 0;
  int i_grants = 0;
  int d_grants = 0;
  int ad_cnt   = 0;
  int ad_dly   = 4;
  logic prev_op = 1'b0;

  function automatic logic [LINE_W-1:0] rdata_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hC0DE_F00D}};
  endfunction

  function automatic logic [SB_W-1:0] sb_item(input logic is_i, input logic wr,
                                              input logic [ADDR_W-1:0] a);
    return {is_i, wr, ~wr, a};
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  // ---------------- adaptor model ----------------
  // Pulses resp ad_dly cycles after the first cycle an op is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        c_pmem_resp = 1'b0;
        ad_cnt = 0;
      end else if (c_pmem_resp) begin
        c_pmem_resp  = 1'b0;
        ad_cnt       = 0;
        c_pmem_rdata = {8{$urandom}};
      end else if (c_pmem_read || c_pmem_write) begin
        ad_cnt++;
        if (ad_cnt == ad_dly + 1) begin
          c_pmem_resp  = 1'b1;
          c_pmem_rdata = rdata_of(c_pmem_address);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_d(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] wd);
    d_pmem_address = a;
    d_pmem_wdata   = wd;
    d_pmem_write   = wr;
    d_pmem_read    = ~wr;
  endtask

  task automatic drive_i(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] wd);
    i_pmem_address = a;
    i_pmem_wdata   = wd;
    i_pmem_write   = wr;
    i_pmem_read    = ~wr;
  endtask

  function automatic logic pending();
    return i_pmem_read | i_pmem_write | d_pmem_read | d_pmem_write;
  endfunction

  // One cycle: sample after the falling edge, score grants and responses,
  // retire requests whose resp arrived.
  task automatic step();
    logic op;
    logic [SB_W-1:0] got;
    @(negedge clk);
    #1;
    op = c_pmem_read | c_pmem_write;
    if (op && !prev_op) begin
      got = {o_dbg_state == BUSY_I, c_pmem_write, c_pmem_read, c_pmem_address};
      if (o_dbg_state == BUSY_I) i_grants++;
      else d_grants++;
      check("sb_nonempty", LINE_W'(exp_q.size() != 0), LINE_W'(1));
      if (exp_q.size() != 0) check("grant", LINE_W'(got), LINE_W'(exp_q.pop_front()));
    end
    prev_op = op;
    if (d_pmem_resp) begin
      check("d_rdata", d_pmem_rdata, rdata_of(d_pmem_address));
      check("d_resp_solo", LINE_W'(i_pmem_resp), LINE_W'(0));
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      d_done++;
    end else if (i_pmem_resp) begin
      check("i_rdata", i_pmem_rdata, rdata_of(i_pmem_address));
      i_pmem_read  = 1'b0;
      i_pmem_write = 1'b0;
      i_done++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((pending() || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, LINE_W'({pending(), exp_q.size() != 0}), LINE_W'(0));
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] s3_addr[5];
  logic              s3_wr[5];
  logic [LINE_W-1:0] wd0;
  int d0;
  int resp_at;
  int d_sent;
  bit seen_i;
  bit seen_d4;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_strobes", LINE_W'({c_pmem_read, c_pmem_write, i_pmem_resp, d_pmem_resp}), LINE_W'(0));
    check("rst_addr", LINE_W'(c_pmem_address), LINE_W'(0));
    check("rst_wdata", c_pmem_wdata, LINE_W'(0));
    check("rst_state_cnt", LINE_W'({o_dbg_state, o_dbg_starve_cnt}), LINE_W'(0));
    reset_n = 1'b1;
    step();

    // simultaneous I read / D write: D first, then I
    exp_q.push_back(sb_item(1'b0, 1'b1, 32'h0000_0200));
    exp_q.push_back(sb_item(1'b1, 1'b0, 32'h0000_0100));
    drive_d(1'b1, 32'h0000_0200, {8{$urandom}});
    drive_i(1'b0, 32'h0000_0100, '0);
    drain("s2_drain", 60);
    check("s2_done", LINE_W'({i_done, d_done}), LINE_W'({32'd1, 32'd1}));
`ifdef ARB_PERF_CNT_EN
    check("perf_i", LINE_W'(perf_i_grants), LINE_W'(1));
    check("perf_d", LINE_W'(perf_d_grants), LINE_W'(1));
    check("perf_conflict", LINE_W'(perf_conflict), LINE_W'(1));
`endif

    // lone D read with fixed adaptor latency
    ad_dly = 4;
    exp_q.push_back(sb_item(1'b0, 1'b0, 32'h0000_1000));
    drive_d(1'b0, 32'h0000_1000, '0);
    d0 = d_done;
    step();
    check("s1_cread_n1", LINE_W'(c_pmem_read), LINE_W'(1));
    check("s1_state_n1", LINE_W'(o_dbg_state), LINE_W'(BUSY_D));
    resp_at = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (d_done != d0) begin
        resp_at = k;
        break;
      end
    end
    check("s1_resp_lat", LINE_W'(resp_at), LINE_W'(5));
    step();
    check("s1_idle", LINE_W'({o_dbg_state, c_pmem_read}), LINE_W'(0));

    // stray adaptor resp while idle
    c_pmem_resp = 1'b1;
    #1;
    check("idle_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), LINE_W'(0));
    step();
    check("idle_resp_state", LINE_W'(o_dbg_state), LINE_W'(IDLE));

    // starvation: D back-to-back, I held throughout
    ad_dly = $urandom_range(1, 6);
    for (int k = 0; k < 5; k++) begin
      s3_addr[k] = {$urandom_range(0, 32'h00FF_FFFF), 5'b0} & 32'h1FFF_FFE0;
      s3_wr[k]   = $urandom_range(0, 1) == 1;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(sb_item(1'b0, s3_wr[k], s3_addr[k]));
    exp_q.push_back(sb_item(1'b1, 1'b0, 32'h0000_0400));
    exp_q.push_back(sb_item(1'b0, s3_wr[4], s3_addr[4]));
    i_grants = 0;
    d_grants = 0;
    seen_i   = 1'b0;
    seen_d4  = 1'b0;
    drive_i(1'b0, 32'h0000_0400, '0);
    drive_d(s3_wr[0], s3_addr[0], {8{$urandom}});
    d_sent = 1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (d_grants == 4 && !seen_d4) begin
        seen_d4 = 1'b1;
        check("s3_cnt_sat", LINE_W'(o_dbg_starve_cnt), LINE_W'(LIMIT));
      end
      if (i_grants == 1 && !seen_i) begin
        seen_i = 1'b1;
        check("s3_d_before_i", LINE_W'(d_grants), LINE_W'(4));
        check("s3_cnt_clr", LINE_W'(o_dbg_starve_cnt), LINE_W'(0));
      end
      if (!d_pmem_read && !d_pmem_write && d_sent < 5) begin
        drive_d(s3_wr[d_sent], s3_addr[d_sent], {8{$urandom}});
        d_sent++;
      end
      if (d_sent == 5 && !pending() && exp_q.size() == 0) break;
    end
    drain("s3_drain", 40);
    check("s3_grants", LINE_W'({i_grants, d_grants}), LINE_W'({32'd1, 32'd5}));

    // D write with wdata changed mid-burst
    ad_dly = 4;
    wd0 = {8{$urandom}};
    exp_q.push_back(sb_item(1'b0, 1'b1, 32'h0000_0300));
    drive_d(1'b1, 32'h0000_0300, wd0);
    step();
    check("s4_wdata_grant", c_pmem_wdata, wd0);
    d_pmem_wdata = ~wd0;
    step();
    check("s4_wdata_mid", c_pmem_wdata, wd0);
    check("s4_i_quiet", LINE_W'(i_pmem_resp), LINE_W'(0));
    drain("s4_drain", 30);
    check("s4_wdata_end", c_pmem_wdata, wd0);

    // I write alone
    exp_q.push_back(sb_item(1'b1, 1'b1, 32'h0000_0700));
    drive_i(1'b1, 32'h0000_0700, {8{$urandom}});
    drain("s4b_drain", 30);

    // reset two cycles into a D burst
    exp_q.push_back(sb_item(1'b0, 1'b0, 32'h0000_0500));
    drive_d(1'b0, 32'h0000_0500, '0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("s5_rst_strobes", LINE_W'({c_pmem_read, c_pmem_write, i_pmem_resp, d_pmem_resp}), LINE_W'(0));
    check("s5_rst_addr", LINE_W'(c_pmem_address), LINE_W'(0));
    check("s5_rst_state", LINE_W'({o_dbg_state, o_dbg_starve_cnt}), LINE_W'(0));
    d_pmem_read = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    exp_q.push_back(sb_item(1'b1, 1'b0, 32'h0000_0600));
    drive_i(1'b0, 32'h0000_0600, '0);
    step();
    check("s5_i_grant", LINE_W'({o_dbg_state, c_pmem_read}), LINE_W'({BUSY_I, 1'b1}));
    drain("s5_drain", 30);
    check("s5_idle", LINE_W'(o_dbg_state), LINE_W'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
